fifo_step_player: RTL and testbench

- Downstream consumer of the motion command `fifo`. It pops one entry at a time and turns each entry into a single step pulse on a stepper driver.
- Each entry carries a direction bit and a delay, in clk cycles, to wait before the pulse.
- Sits between the `fifo` read side and the stepper driver pins. It guarantees deterministic step timing and flags an underrun when the queue runs dry mid-motion.

---
 rtl/fifo_step_player_pkg.sv | 27 ++
 rtl/fifo_step_player_if.sv | 11 +
 rtl/fifo_step_player_step_pulse_timer.sv | 28 ++
 rtl/fifo_step_player.sv | 130 +++++++++++++
 tb/tb_fifo_step_player.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_step_player_pkg.sv
// Shared definitions for the FIFO-driven step player: FSM encoding and
// FIFO word field helpers.
package step_player_defs;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    DELAY = 3'd3,
    PULSE = 3'd4
  } state_t;

  // The MSB of a FIFO word is the direction; the rest is the delay.
  function automatic int dir_bit_of(input int data_width);
    return data_width - 1;
  endfunction

  function automatic int delay_msb_of(input int data_width);
    return data_width - 2;
  endfunction

  // Counter must hold both the largest delay and a PULSE_WIDTH of up to 255.
  function automatic int cnt_width_of(input int data_width);
    return (data_width - 1 > 8) ? data_width - 1 : 8;
  endfunction

endpackage

// File: rtl/fifo_step_player_if.sv
// Read-side handshake between the motion command FIFO and the step player.
interface fifo_step_player_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_read;

  modport master (input fifo_empty, input fifo_data, output fifo_read);
  modport slave  (output fifo_empty, output fifo_data, input fifo_read);
endinterface

// File: rtl/fifo_step_player_step_pulse_timer.sv
// Loadable down-counter shared by the DELAY and PULSE phases; last flags
// the final cycle of the loaded interval.
module step_pulse_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             last
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign last = (count_reg == WIDTH'(1));

endmodule

// File: rtl/fifo_step_player.sv
// Pops motion entries from the command FIFO and emits one timed step pulse
// per entry. Optional position counter: define STEP_PLAYER_POSITION_EN.
module fifo_step_player
  import step_player_defs::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PULSE_WIDTH = 4
`ifdef STEP_PLAYER_POSITION_EN
  , parameter int POS_WIDTH = 32
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  fifo_step_player_if.master fifo,
  output logic               step,
  output logic               dir,
  output logic               busy,
  output logic               underrun,
  input  logic               underrun_clear
`ifdef STEP_PLAYER_POSITION_EN
  , output logic signed [POS_WIDTH-1:0] position
  , input  logic                        position_load
  , input  logic        [POS_WIDTH-1:0] position_value
`endif
);

  localparam int DIR_BIT   = dir_bit_of(DATA_WIDTH);
  localparam int DELAY_MSB = delay_msb_of(DATA_WIDTH);
  localparam int CNT_W     = cnt_width_of(DATA_WIDTH);

  state_t             state_reg, state_next;
  logic               dir_reg, step_reg, underrun_reg;
  logic               timer_load, timer_dec, timer_last, underrun_set;
  logic [CNT_W-1:0]   timer_value;
  logic [CNT_W-1:0]   delay_value;

  // A zero delay still spends one cycle in DELAY.
  assign delay_value = (fifo.fifo_data[DELAY_MSB:0] == '0) ? CNT_W'(1)
                                                           : CNT_W'(fifo.fifo_data[DELAY_MSB:0]);

  always_comb begin
    state_next   = state_reg;
    timer_load   = 1'b0;
    timer_dec    = 1'b0;
    timer_value  = delay_value;
    underrun_set = 1'b0;
    case (state_reg)
      IDLE:  if (enable && !fifo.fifo_empty) state_next = FETCH;
      FETCH: state_next = LATCH;
      LATCH: begin
        timer_load = 1'b1;
        state_next = DELAY;
      end
      DELAY: begin
        if (timer_last) begin
          timer_load  = 1'b1;
          timer_value = CNT_W'(PULSE_WIDTH);
          state_next  = PULSE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      PULSE: begin
        if (timer_last) begin
          if (enable && !fifo.fifo_empty) begin
            state_next = FETCH;
          end else begin
            underrun_set = enable;
            state_next   = IDLE;
          end
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      dir_reg      <= 1'b0;
      step_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Registered so step mirrors the PULSE state without decode glitches.
      step_reg  <= (state_next == PULSE);
      if (state_reg == LATCH) dir_reg <= fifo.fifo_data[DIR_BIT];
      if (underrun_set)        underrun_reg <= 1'b1;
      else if (underrun_clear) underrun_reg <= 1'b0;
    end
  end

  step_pulse_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .dec        (timer_dec),
    .last       (timer_last)
  );

  assign fifo.fifo_read = (state_reg == FETCH);
  assign busy           = (state_reg != IDLE);
  assign step           = step_reg;
  assign dir            = dir_reg;
  assign underrun       = underrun_reg;

`ifdef STEP_PLAYER_POSITION_EN
  logic signed [POS_WIDTH-1:0] position_reg;

  // Counts on entry to PULSE so the position moves together with step rising.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      position_reg <= '0;
    end else if (position_load) begin
      position_reg <= position_value;
    end else if (state_reg != PULSE && state_next == PULSE) begin
      position_reg <= dir_reg ? position_reg + 1'b1 : position_reg - 1'b1;
    end
  end

  assign position = position_reg;
`endif

endmodule

// File: tb/tb_fifo_step_player.sv
// Directed self-checking bench for fifo_step_player with a small FIFO model
// that returns read data one cycle after fifo_read.
module tb_fifo_step_player;

  logic clk;
  logic reset;
  logic enable;
  logic underrun_clear;
  logic step, dir, busy, underrun;

  int n_checks;
  int n_fail;

  fifo_step_player_if #(.DATA_WIDTH(8)) fb ();

`ifdef STEP_PLAYER_POSITION_EN
  logic signed [31:0] position;
  logic               position_load;
  logic [31:0]        position_value;
`endif

  fifo_step_player #(
    .DATA_WIDTH  (8),
    .PULSE_WIDTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .fifo           (fb.master),
    .step           (step),
    .dir            (dir),
    .busy           (busy),
    .underrun       (underrun),
    .underrun_clear (underrun_clear)
`ifdef STEP_PLAYER_POSITION_EN
    , .position       (position)
    , .position_load  (position_load)
    , .position_value (position_value)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model with registered read data
  logic [7:0] mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fb.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fb.fifo_read) begin
      fb.fifo_data <= mem[rd_ptr[4:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] v);
    mem[wr_ptr[4:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b0;
    enable         = 1'b0;
    underrun_clear = 1'b0;
    wr_ptr         = rd_ptr;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_fetch(output logic found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (fb.fifo_read) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b0;
    underrun_clear = 1'b0;
`ifdef STEP_PLAYER_POSITION_EN
    position_load  = 1'b0;
    position_value = '0;
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if ({fb.fifo_read, step, dir, busy, underrun} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got read/step/dir/busy/underrun=%b want 00000",
               {fb.fifo_read, step, dir, busy, underrun});
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_empty: busy=%b want 0", busy);
    end
  endtask

  task automatic test_single_entry();
    logic found;
    logic e_read, e_dir, e_step, e_busy, e_under;
    do_reset();
    push(8'h83);
    enable = 1'b1;
    wait_fetch(found);
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL single_fetch_timeout: fifo_read=0 want 1 within 20 cycles");
      return;
    end
    for (int off = 0; off <= 10; off++) begin
      if (off > 0) @(negedge clk);
      e_read  = (off == 0);
      e_dir   = (off >= 2);
      e_step  = (off >= 5 && off <= 8);
      e_busy  = (off <= 8);
      e_under = (off >= 9);
      n_checks++;
      if ({fb.fifo_read, dir, step, busy, underrun} !== {e_read, e_dir, e_step, e_busy, e_under}) begin
        n_fail++;
        $display("FAIL single_t+%0d: read/dir/step/busy/underrun=%b want %b", off,
                 {fb.fifo_read, dir, step, busy, underrun},
                 {e_read, e_dir, e_step, e_busy, e_under});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic found, prev;
    int   nr;
    int   rise [3];
    logic rdir [3];
    int   exp_rise [3] = '{4, 11, 18};
    logic exp_dir  [3] = '{1'b0, 1'b1, 1'b0};
    do_reset();
    push(8'h02);
    push(8'h81);
    push(8'h00);
    enable = 1'b1;
    wait_fetch(found);
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL b2b_fetch_timeout: fifo_read=0 want 1 within 20 cycles");
      return;
    end
    nr = 0;
    prev = step;
    for (int off = 1; off <= 30; off++) begin
      @(negedge clk);
      if (step && !prev) begin
        if (nr < 3) begin
          rise[nr] = off;
          rdir[nr] = dir;
        end
        nr++;
      end
      prev = step;
    end
    n_checks++;
    if (nr !== 3) begin
      n_fail++;
      $display("FAIL b2b_step_count: got %0d want 3", nr);
    end
    for (int k = 0; k < 3 && k < nr; k++) begin
      n_checks++;
      if (rise[k] !== exp_rise[k]) begin
        n_fail++;
        $display("FAIL b2b_rise%0d: step rose at t+%0d want t+%0d", k, rise[k], exp_rise[k]);
      end
      n_checks++;
      if (rdir[k] !== exp_dir[k]) begin
        n_fail++;
        $display("FAIL b2b_dir%0d: dir=%b want %b", k, rdir[k], exp_dir[k]);
      end
    end
    n_checks++;
    if (underrun !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: underrun=%b busy=%b want 1 0", underrun, busy);
    end
  endtask

  task automatic test_enable_drop();
    logic found, prev;
    int   nr, nreads;
    do_reset();
    push(8'h05);
    push(8'h85);
    push(8'h05);
    enable = 1'b1;
    wait_fetch(found);
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL drop_fetch_timeout: fifo_read=0 want 1 within 20 cycles");
      return;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || step !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_in_delay: busy=%b step=%b want 1 0", busy, step);
    end
    enable = 1'b0;
    nr = 0;
    nreads = 0;
    prev = step;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (step && !prev) nr++;
      if (fb.fifo_read) nreads++;
      prev = step;
    end
    n_checks++;
    if (nr !== 1) begin
      n_fail++;
      $display("FAIL drop_steps: got %0d want 1", nr);
    end
    n_checks++;
    if (nreads !== 0 || (wr_ptr - rd_ptr) !== 2) begin
      n_fail++;
      $display("FAIL drop_remaining: extra reads=%0d left=%0d want 0 2", nreads, wr_ptr - rd_ptr);
    end
    n_checks++;
    if (underrun !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_end: underrun=%b busy=%b want 0 0", underrun, busy);
    end
  endtask

  task automatic test_underrun_collision();
    logic found, seen;
    do_reset();
    push(8'h83);
    underrun_clear = 1'b1;
    enable = 1'b1;
    wait_fetch(found);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (step) seen = 1'b1;
    end
    for (int i = 0; i < 20 && step; i++) @(negedge clk);
    n_checks++;
    if (!found || !seen || step !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_timeout: fetch=%b step_seen=%b step=%b want 1 1 0", found, seen, step);
    end
    underrun_clear = 1'b0;
    n_checks++;
    if (underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_set_wins: underrun=%b want 1", underrun);
    end
    @(negedge clk);
    n_checks++;
    if (underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_sticky: underrun=%b want 1", underrun);
    end
    underrun_clear = 1'b1;
    @(negedge clk);
    underrun_clear = 1'b0;
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_clear: underrun=%b want 0", underrun);
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic found;
    do_reset();
    push(8'h83);
    push(8'h03);
    enable = 1'b1;
    wait_fetch(found);
    repeat (6) @(negedge clk);
    n_checks++;
    if (!found || step !== 1'b1) begin
      n_fail++;
      $display("FAIL midpulse_setup: fetch=%b step=%b want 1 1", found, step);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({step, busy, fb.fifo_read} !== 3'b000) begin
      n_fail++;
      $display("FAIL midpulse_async: step/busy/read=%b want 000", {step, busy, fb.fifo_read});
    end
    enable = 1'b0;
    wr_ptr = rd_ptr;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({step, busy, underrun} !== 3'b000) begin
      n_fail++;
      $display("FAIL midpulse_after: step/busy/underrun=%b want 000", {step, busy, underrun});
    end
  endtask

`ifdef STEP_PLAYER_POSITION_EN
  task automatic test_position();
    do_reset();
    n_checks++;
    if (position !== 32'sd0) begin
      n_fail++;
      $display("FAIL pos_reset: position=%h want 00000000", position);
    end
    position_load  = 1'b1;
    position_value = 32'h7FFF_FFFF;
    @(negedge clk);
    position_load = 1'b0;
    n_checks++;
    if (position !== 32'h7FFF_FFFF) begin
      n_fail++;
      $display("FAIL pos_load: position=%h want 7fffffff", position);
    end
    push(8'h81);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (position !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL pos_wrap: position=%h want 80000000", position);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_entry();
    test_back_to_back();
    test_enable_drop();
    test_underrun_collision();
    test_reset_mid_pulse();
`ifdef STEP_PLAYER_POSITION_EN
    test_position();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
